// File: rtl/jtdd_mcu_bridge_pkg.sv
// Shared types for the MCU bridge.
//   halt_state_t : halt handshake FSM states (RUN, WAIT, HALTED)
//   IRQ_CNT_W    : width of the main IRQ pulse counter
package jtdd_mcu_bridge_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_t;

    localparam int unsigned IRQ_CNT_W = 4;

endpackage

// File: rtl/jtdd_mcu_bridge_ram.sv
// True dual-port byte RAM with registered, read-first outputs.
//   clk, rst            : clock; rst clears only the read registers
//   a_addr/a_we/a_data  : port A address, write enable, write data
//   a_q                 : port A read data, valid 1 clk after a_addr
//   b_addr/b_we/b_data  : port B address, write enable, write data
//   b_q                 : port B read data, valid 1 clk after b_addr
// Same-address write collisions must be resolved by the caller.
module jtdd_mcu_bridge_ram #(
    parameter int unsigned AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic [7:0]    a_data,
    output logic [7:0]    a_q,
    input  logic [AW-1:0] b_addr,
    input  logic          b_we,
    input  logic [7:0]    b_data,
    output logic [7:0]    b_q
);

    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] a_q_d, a_q_q;
    logic [7:0] b_q_d, b_q_q;

    always_ff @(posedge clk) begin
        if (b_we) mem[b_addr] <= b_data;
        if (a_we) mem[a_addr] <= a_data;
    end

    // Reading the array before the edge gives read-first behaviour.
    always_comb begin
        a_q_d = mem[a_addr];
        b_q_d = mem[b_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q_q <= '0;
            b_q_q <= '0;
        end else begin
            a_q_q <= a_q_d;
            b_q_q <= b_q_d;
        end
    end

    assign a_q = a_q_q;
    assign b_q = b_q_q;

endmodule

// File: rtl/jtdd_mcu_bridge.sv
// MCU-side responder for the main CPU's MCU interface.
//   clk, rst                    : clock, asynchronous active-high reset
//   main_cen / mcu_cen_in       : main CPU and raw MCU clock enables
//   mcu_cen                     : MCU clock enable, gated off while halted
//   main_cs/addr/rnw/dout/din   : main CPU com RAM port
//   mcu_cs/addr/we/dout/din     : MCU com RAM port
//   nmi_set, mcu_nmi_ack        : NMI latch set (main) / clear (MCU)
//   mcu_nmi                     : NMI level to the MCU
//   halt_req, mcu_ibound, ban   : halt request, MCU instruction boundary,
//                                 bus-available reply
//   mcu_irq_req, irqmain        : MCU request and IRQ pulse to main
module jtdd_mcu_bridge
    import jtdd_mcu_bridge_pkg::*;
#(
    parameter int unsigned AW      = 9,
    parameter int unsigned IRQ_LEN = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          main_cen,
    input  logic          mcu_cen_in,
    output logic          mcu_cen,
    input  logic          main_cs,
    input  logic [AW-1:0] main_addr,
    input  logic          main_rnw,
    input  logic [7:0]    main_dout,
    output logic [7:0]    main_din,
    input  logic          nmi_set,
    input  logic          halt_req,
    output logic          ban,
    input  logic          mcu_cs,
    input  logic [AW-1:0] mcu_addr,
    input  logic          mcu_we,
    input  logic [7:0]    mcu_dout,
    output logic [7:0]    mcu_din,
    input  logic          mcu_ibound,
    output logic          mcu_nmi,
    input  logic          mcu_nmi_ack,
    input  logic          mcu_irq_req,
    output logic          irqmain
);

    localparam logic [IRQ_CNT_W-1:0] IRQ_LOAD = IRQ_LEN[IRQ_CNT_W-1:0];

    halt_state_t          state_q, state_d;
    logic                 ban_q, ban_d;
    logic                 nmi_q, nmi_d;
    logic [IRQ_CNT_W-1:0] irq_cnt_q, irq_cnt_d;
    logic                 irq_q, irq_d;

    logic halted;
    logic main_wr, mcu_wr_req, mcu_wr;

    assign halted  = (state_q == ST_HALTED);
    // Held low during reset so the MCU core cannot advance while rst is high.
    assign mcu_cen = mcu_cen_in & ~halted & ~rst;

    // ---------------------------------------------------------------
    // com RAM: main write wins on a same-address collision
    // ---------------------------------------------------------------
    always_comb begin
        main_wr    = main_cs & ~main_rnw & main_cen;
        mcu_wr_req = mcu_cs & mcu_we & mcu_cen;
        mcu_wr     = mcu_wr_req & ~(main_wr & (main_addr == mcu_addr));
    end

    jtdd_mcu_bridge_ram #(
        .AW (AW)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .a_addr (main_addr),
        .a_we   (main_wr),
        .a_data (main_dout),
        .a_q    (main_din),
        .b_addr (mcu_addr),
        .b_we   (mcu_wr),
        .b_data (mcu_dout),
        .b_q    (mcu_din)
    );

    // ---------------------------------------------------------------
    // Halt handshake
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (halt_req) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!halt_req)                     state_d = ST_RUN;
                else if (mcu_cen_in && mcu_ibound) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (!halt_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        // Registered from the next state so ban tracks HALTED exactly,
        // dropping on the same edge that leaves it.
        ban_d = (state_d == ST_HALTED);
    end

    // ---------------------------------------------------------------
    // NMI latch: set has priority over a simultaneous acknowledge
    // ---------------------------------------------------------------
    always_comb begin
        nmi_d = nmi_q;
        if (nmi_set && main_cen)             nmi_d = 1'b1;
        else if (mcu_nmi_ack && mcu_cen_in)  nmi_d = 1'b0;
    end

    // ---------------------------------------------------------------
    // IRQ pulse to main: a reload while active only stretches the pulse
    // ---------------------------------------------------------------
    always_comb begin
        irq_cnt_d = irq_cnt_q;
        if (mcu_irq_req && mcu_cen_in)
            irq_cnt_d = IRQ_LOAD;
        else if (main_cen && (irq_cnt_q != '0))
            irq_cnt_d = irq_cnt_q - 1'b1;
        irq_d = (irq_cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            ban_q     <= 1'b0;
            nmi_q     <= 1'b0;
            irq_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ban_q     <= ban_d;
            nmi_q     <= nmi_d;
            irq_cnt_q <= irq_cnt_d;
            irq_q     <= irq_d;
        end
    end

    assign ban     = ban_q;
    assign mcu_nmi = nmi_q;
    assign irqmain = irq_q;

endmodule
